// File: rtl/div_if.sv
// Request/result bundle between control logic and the iterative divider.
// The div_unsigned field exists only when DIVU_EN is defined.
interface div_if #(
    parameter int WIDTH = 32
);
    logic             div_start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
`ifdef DIVU_EN
    logic             div_unsigned;
`endif
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output div_start, dividend, divisor,
`ifdef DIVU_EN
        output div_unsigned,
`endif
        input  hi_out, lo_out, busy, done, div_zero
    );

    modport slave (
        input  div_start, dividend, divisor,
`ifdef DIVU_EN
        input  div_unsigned,
`endif
        output hi_out, lo_out, busy, done, div_zero
    );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider: quotient on lo_out, remainder on hi_out, signed by default.
// Optional macro DIVU_EN adds the div_unsigned request field (DIVU semantics).
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic  clock,
    input  logic  reset,
    div_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic             sign_mode;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

`ifdef DIVU_EN
    assign sign_mode = ~bus.div_unsigned;
`else
    assign sign_mode = 1'b1;
`endif

    // The partial remainder is always below the divisor, so the extra top bit of
    // the difference is a pure borrow flag: clear means shifted >= divisor.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.div_start) begin
                    if (bus.divisor == '0) begin
                        dz_d = 1'b1;
                    end else begin
                        quo_d   = cond_neg(bus.dividend, sign_mode & bus.dividend[WIDTH-1]);
                        dvs_d   = cond_neg(bus.divisor, sign_mode & bus.divisor[WIDTH-1]);
                        rem_d   = '0;
                        count_d = CNT_W'(WIDTH);
                        q_neg_d = sign_mode & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                        r_neg_d = sign_mode & bus.dividend[WIDTH-1];
                        busy_d  = 1'b1;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                lo_d    = cond_neg(quo_q, q_neg_q);
                hi_d    = cond_neg(rem_q, r_neg_q);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: reference quotient/remainder queued at request time,
// popped and compared when done pulses.
module tb_div_unit;
    localparam int W = 32;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    div_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model in 64-bit arithmetic, which truncates toward zero and
    // handles most-negative / -1 without overflow.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic uns);
        longint sa, sb, q, r;
        if (uns) begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        q = sa / sb;
        r = sa % sb;
        return {r[W-1:0], q[W-1:0]};
    endfunction

    // Issues a request in the current cycle and waits for its completion.
    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic uns);
        int n;
        int dz;
        logic [2*W-1:0] e;
        bus.dividend  = a;
        bus.divisor   = b;
`ifdef DIVU_EN
        bus.div_unsigned = uns;
`endif
        bus.div_start = 1'b1;
        exp_q.push_back(model(a, b, uns));
        tick();
        bus.div_start = 1'b0;
        bus.dividend  = $urandom;
        bus.divisor   = $urandom;
        n  = 0;
        dz = 0;
        chk({tag, "_busy_start"}, W'(bus.busy), W'(1));
        while (bus.done !== 1'b1 && n < 100) begin
            tick();
            n++;
            if (bus.div_zero === 1'b1) dz++;
        end
        chk({tag, "_latency"}, W'(n), W'(W + 1));
        e = exp_q.pop_front();
        chk({tag, "_lo"}, bus.lo_out, e[W-1:0]);
        chk({tag, "_hi"}, bus.hi_out, e[2*W-1:W]);
        chk({tag, "_busy_end"}, W'(bus.busy), W'(0));
        chk({tag, "_no_dz"}, W'(dz), W'(0));
    endtask

    initial begin
        int cnt;
        reset         = 1'b1;
        bus.div_start = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
`ifdef DIVU_EN
        bus.div_unsigned = 1'b0;
`endif
        repeat (2) tick();
        chk("rst_hi", bus.hi_out, '0);
        chk("rst_lo", bus.lo_out, '0);
        chk("rst_busy", W'(bus.busy), W'(0));
        chk("rst_done", W'(bus.done), W'(0));
        chk("rst_dz", W'(bus.div_zero), W'(0));
        reset = 1'b0;
        tick();

        // Back-to-back requests: each starts in the done cycle of the previous one.
        run_div("d100_7", 32'd100, 32'd7, 1'b0);
        chk("d100_7_lo_const", bus.lo_out, 32'd14);
        chk("d100_7_hi_const", bus.hi_out, 32'd2);
        run_div("dm7_2", 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("dm7_2_lo_const", bus.lo_out, 32'hFFFF_FFFD);
        chk("dm7_2_hi_const", bus.hi_out, 32'hFFFF_FFFF);
        run_div("d7_m2", 32'd7, 32'hFFFF_FFFE, 1'b0);
        chk("d7_m2_lo_const", bus.lo_out, 32'hFFFF_FFFD);
        chk("d7_m2_hi_const", bus.hi_out, 32'd1);
        run_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("ovf_lo_const", bus.lo_out, 32'h8000_0000);
        chk("ovf_hi_const", bus.hi_out, 32'd0);
        tick();
        chk("ovf_done_once", W'(bus.done), W'(0));

        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            b = $urandom;
            if (i[0]) b = b >> ($urandom_range(W - 2, 8));
            if (b == '0) b = 32'd3;
            run_div($sformatf("rnd%0d", i), a, b, 1'b0);
        end

        // Divide by zero after a 100/7 preload.
        run_div("pre", 32'd100, 32'd7, 1'b0);
        bus.dividend  = 32'd5;
        bus.divisor   = 32'd0;
        bus.div_start = 1'b1;
        tick();
        bus.div_start = 1'b0;
        chk("dz_pulse", W'(bus.div_zero), W'(1));
        chk("dz_busy", W'(bus.busy), W'(0));
        chk("dz_done", W'(bus.done), W'(0));
        chk("dz_hi", bus.hi_out, 32'd2);
        chk("dz_lo", bus.lo_out, 32'd14);
        tick();
        chk("dz_one_cycle", W'(bus.div_zero), W'(0));
        cnt = 0;
        repeat (40) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) cnt++;
        end
        chk("dz_no_activity", W'(cnt), W'(0));

        // Ignored request while busy, then reset aborts the divide.
        bus.dividend  = 32'd100;
        bus.divisor   = 32'd7;
        bus.div_start = 1'b1;
        tick();
        bus.div_start = 1'b0;
        repeat (9) tick();
        bus.dividend  = 32'd9;
        bus.divisor   = 32'd3;
        bus.div_start = 1'b1;
        tick();
        bus.div_start = 1'b0;
        chk("ign_busy", W'(bus.busy), W'(1));
        chk("ign_lo_hold", bus.lo_out, 32'd14);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", W'(bus.busy), W'(0));
        chk("abort_hi", bus.hi_out, '0);
        chk("abort_lo", bus.lo_out, '0);
        cnt = 0;
        repeat (60) begin
            if (bus.done === 1'b1 || bus.div_zero === 1'b1 || bus.busy === 1'b1) cnt++;
            tick();
        end
        chk("abort_quiet", W'(cnt), W'(0));
        run_div("d9_3", 32'd9, 32'd3, 1'b0);
        chk("d9_3_lo_const", bus.lo_out, 32'd3);

`ifdef DIVU_EN
        run_div("divu", 32'hFFFF_FFFF, 32'd2, 1'b1);
        chk("divu_lo_const", bus.lo_out, 32'h7FFF_FFFF);
        chk("divu_hi_const", bus.hi_out, 32'd1);
        run_div("divs", 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("divs_lo_const", bus.lo_out, 32'd0);
        chk("divs_hi_const", bus.hi_out, 32'hFFFF_FFFF);
`endif

        chk("sb_empty", W'(exp_q.size()), W'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
